// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports plus one write-back port.
// The master side (decode/write-back) drives addresses and write data;
// the slave side (the register file) returns the two read operands.
interface reg_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] Read_Add_1;
  logic [ADDR_W-1:0] Read_Add_2;
  logic [ADDR_W-1:0] Write_Add;
  logic              Write_enable;
  logic [DATA_W-1:0] Write_data;
  logic [DATA_W-1:0] Read_data_1;
  logic [DATA_W-1:0] Read_data_2;

  modport master (
    output Read_Add_1, Read_Add_2, Write_Add, Write_enable, Write_data,
    input  Read_data_1, Read_data_2
  );

  modport slave (
    input  Read_Add_1, Read_Add_2, Write_Add, Write_enable, Write_data,
    output Read_data_1, Read_data_2
  );
endinterface

// File: rtl/reg_file.sv
// 8 x 16-bit general-purpose register file for the decode stage.
// Two combinational read ports, one synchronous write port, and a
// same-cycle write-to-read bypass so decode sees the value being committed.
// R0 is an ordinary writable register.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              hit_1;
  logic              hit_2;
  logic [DATA_W-1:0] rd_1;
  logic [DATA_W-1:0] rd_2;

  // Storage update: reset clears every register and wins over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset explicitly because the reset value is
      // architecturally visible (all registers read 0); this costs a flop array
      // instead of a RAM macro, which is fine at eight entries.
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignments keep every register update on the same
        // edge, independent of statement order.
        mem[i] <= '0;
      end
    end else if (bus.Write_enable) begin
      mem[bus.Write_Add] <= bus.Write_data;
    end
  end

  // Bypass detection: a live write to the same address overrides the stored value.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    if (!rst && bus.Write_enable) begin
      hit_1 = (bus.Write_Add == bus.Read_Add_1);
      hit_2 = (bus.Write_Add == bus.Read_Add_2);
    end
  end

  // Read muxes: stored content, or the in-flight write data on a bypass hit.
  always_comb begin
    rd_1 = mem[bus.Read_Add_1];
    rd_2 = mem[bus.Read_Add_2];
    if (hit_1) rd_1 = bus.Write_data;
    if (hit_2) rd_2 = bus.Write_data;
  end

  assign bus.Read_data_1 = rd_1;
  assign bus.Read_data_2 = rd_2;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a table of one-cycle vectors with
// hand-computed expected read data, plus a hand-written reset-vs-write sequence.
module tb_reg_file;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct {
    bit              chk;
    logic            rst;
    logic            we;
    logic [2:0]      wa;
    logic [15:0]     wd;
    logic [2:0]      ra1;
    logic [2:0]      ra2;
    logic [15:0]     e1;
    logic [15:0]     e2;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  reg_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit chk, logic r, logic we, logic [2:0] wa,
                              logic [15:0] wd, logic [2:0] ra1, logic [2:0] ra2,
                              logic [15:0] e1, logic [15:0] e2);
    vec_t v;
    v.chk = chk; v.rst = r;   v.we  = we;  v.wa = wa; v.wd = wd;
    v.ra1 = ra1; v.ra2 = ra2; v.e1  = e1;  v.e2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] ra1, input logic [2:0] ra2);
    rst              = r;
    bus.Write_enable = we;
    bus.Write_Add    = wa;
    bus.Write_data   = wd;
    bus.Read_Add_1   = ra1;
    bus.Read_Add_2   = ra2;
  endtask

  initial begin
    // Test 1: reset, then sweep all addresses for zero.
    vecs.push_back(mk(0, 1, 0, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 3'd0, 16'h0000, 3'd0, 3'd1, 16'h0000, 16'h0000));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), 16'h0000, 16'h0000));
    // Test 2: write R2 with bypass, then stored value.
    vecs.push_back(mk(1, 0, 1, 3'd2, 16'h5555, 3'd2, 3'd3, 16'h5555, 16'h0000));
    vecs.push_back(mk(1, 0, 0, 3'd2, 16'h0000, 3'd2, 3'd3, 16'h5555, 16'h0000));
    // Test 3: disabled write to R5 leaves it zero.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 0, 3'd5, 16'h6666, 3'd2, 3'd5, 16'h5555, 16'h0000));
    // Test 4: both ports bypass R1, then stored; R2 untouched.
    vecs.push_back(mk(1, 0, 1, 3'd1, 16'hFFFF, 3'd1, 3'd1, 16'hFFFF, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 3'd1, 16'h0000, 3'd1, 3'd1, 16'hFFFF, 16'hFFFF));
    vecs.push_back(mk(1, 0, 0, 3'd0, 16'h0000, 3'd1, 3'd2, 16'hFFFF, 16'h5555));
    // Test 5: fill R0..R7 with 0x1110+i (both ports bypass), then read pairs.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 1, 3'(i), 16'(16'h1110 + i), 3'(i), 3'(i),
                        16'(16'h1110 + i), 16'(16'h1110 + i)));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 0, 3'd0, 16'h0000, 3'(i), 3'(7 - i),
                        16'(16'h1110 + i), 16'(16'h1117 - i)));
    // Bypass only on the matching port: write R3, port 2 reads R4 stored.
    vecs.push_back(mk(1, 0, 1, 3'd3, 16'hBEEF, 3'd3, 3'd4, 16'hBEEF, 16'h1114));
    vecs.push_back(mk(1, 0, 0, 3'd3, 16'h0000, 3'd4, 3'd3, 16'h1114, 16'hBEEF));

    drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d rd1", i), bus.Read_data_1, vecs[i].e1);
        check($sformatf("vec%0d rd2", i), bus.Read_data_2, vecs[i].e2);
      end
    end

    // Test 6: reset together with a write to R3 (holding 0xBEEF).
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd3, 16'hABCD, 3'd3, 3'd3);
    #1;
    check("rst_pre_edge rd1 no bypass", bus.Read_data_1, 16'hBEEF);
    check("rst_pre_edge rd2 no bypass", bus.Read_data_2, 16'hBEEF);
    @(negedge clk);
    #1;
    check("rst_held rd1", bus.Read_data_1, 16'h0000);
    check("rst_held rd2", bus.Read_data_2, 16'h0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd3, 16'hABCD, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      bus.Read_Add_1 = 3'(i);
      bus.Read_Add_2 = 3'(7 - i);
      #1;
      check($sformatf("post_rst R%0d", i), bus.Read_data_1, 16'h0000);
      check($sformatf("post_rst R%0d", 7 - i), bus.Read_data_2, 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
